// File: rtl/delta_madd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | delta_madd_pkg                                                           |
// | Shared types and helpers for the delta multiply-add engine:              |
// |   mode_e       - scan mode captured on an accepted clear                 |
// |   state_e      - engine FSM states                                       |
// |   bin_count()  - number of bins for a given index width                  |
// |   decode_mode()- maps the raw 2-bit mode input (11 behaves as MADD)      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package delta_madd_pkg;

  typedef enum logic [1:0] {
    MODE_MIN  = 2'd0,
    MODE_MAX  = 2'd1,
    MODE_MADD = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int bin_count(input int idx_w);
    return 1 << idx_w;
  endfunction

  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b00:   return MODE_MIN;
      2'b01:   return MODE_MAX;
      default: return MODE_MADD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/delta_bin_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | delta_bin_file                                                           |
// | N x BIN_W bin storage. One combinational read port, two write ports that |
// | may fire in the same cycle on distinct addresses. When wr_acc is high    |
// | each write port adds its data to the addressed bin (modulo 2^BIN_W),     |
// | otherwise it overwrites the bin. Bins have no reset.                     |
// | Ports:                                                                   |
// |   clk                          clock                                     |
// |   wr_acc                       1 = accumulate, 0 = overwrite             |
// |   wa_en/wa_addr/wa_data        write port A                              |
// |   wb_en/wb_addr/wb_data        write port B                              |
// |   rd_addr/rd_data              combinational read port                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module delta_bin_file
  import delta_madd_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int BIN_W = 9
) (
  input  logic             clk,
  input  logic             wr_acc,
  input  logic             wa_en,
  input  logic [IDX_W-1:0] wa_addr,
  input  logic [BIN_W-1:0] wa_data,
  input  logic             wb_en,
  input  logic [IDX_W-1:0] wb_addr,
  input  logic [BIN_W-1:0] wb_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [BIN_W-1:0] rd_data
);

  localparam int N = bin_count(IDX_W);

  logic [N-1:0][BIN_W-1:0] w_bins;

  for (genvar gi = 0; gi < N; gi++) begin : g_bin
    logic [BIN_W-1:0] r_val;

    // Port addresses are distinct by construction, so at most one fires here.
    always_ff @(posedge clk) begin
      if (wa_en && (wa_addr == IDX_W'(gi))) begin
        r_val <= wr_acc ? (r_val + wa_data) : wa_data;
      end else if (wb_en && (wb_addr == IDX_W'(gi))) begin
        r_val <= wr_acc ? (r_val + wb_data) : wb_data;
      end
    end

    assign w_bins[gi] = r_val;
  end

  assign rd_data = w_bins[rd_addr];

endmodule
`default_nettype wire

// File: rtl/delta_madd_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | delta_madd_engine                                                        |
// | Holds 2^IDX_W signed bins loaded through a ready/valid port and runs one |
// | of three scans on start: MIN (lowest occupied index), MAX (highest       |
// | occupied index) or MADD (sum of data*(index+1), recovered by double-     |
// | integrating delta-encoded bins from the top index down).                 |
// | Build option: DELTA_MADD_SAT_EN - total saturates at 2^OUT_W-1 and sets  |
// | the sticky ovf flag; when undefined the total wraps and ovf stays 0.     |
// | Ports:                                                                   |
// |   clk, rst_n (async, active-low)                                         |
// |   mode        scan mode, captured on accepted clear                      |
// |   clear/start operation requests, accepted only when idle               |
// |   load_valid/load_ready/load_index/load_data   load port                 |
// |   busy, done  operation status / one-cycle completion pulse              |
// |   result, found, ovf   scan outputs                                      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module delta_madd_engine
  import delta_madd_pkg::*;
#(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 4,
  parameter int BIN_W  = DATA_W + IDX_W + 1,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              clear,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [IDX_W-1:0]  load_index,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  result,
  output logic              found,
  output logic              ovf
);

  localparam int               N        = bin_count(IDX_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e                  r_state;
  mode_e                   r_mode;
  logic [IDX_W-1:0]        r_idx;
  logic signed [BIN_W-1:0] r_delta;
  logic [OUT_W-1:0]        r_count;
  logic [OUT_W-1:0]        r_total;

  logic                    w_load_acc;
  logic [BIN_W-1:0]        w_ld_ext;
  logic                    w_wr_acc;
  logic                    w_wa_en;
  logic [IDX_W-1:0]        w_wa_addr;
  logic [BIN_W-1:0]        w_wa_data;
  logic                    w_wb_en;
  logic [IDX_W-1:0]        w_wb_addr;
  logic [BIN_W-1:0]        w_wb_data;
  logic [BIN_W-1:0]        w_rd;
  logic                    w_rd_nz;
  logic signed [BIN_W-1:0] w_delta_nx;
  logic [OUT_W-1:0]        w_count_nx;
  logic [OUT_W-1:0]        w_total_nx;
  logic                    w_sat;

  // load_ready is high only in IDLE, so loads never collide with CLEAR writes.
  assign w_load_acc = load_valid & load_ready;
  assign w_ld_ext   = BIN_W'(load_data);

  // Bin write steering: CLEAR overwrites the scan index with zero; MIN/MAX
  // loads mark a bin with 1; MADD loads add +d at index and -d just below it.
  always_comb begin
    w_wr_acc  = 1'b0;
    w_wa_en   = 1'b0;
    w_wa_addr = r_idx;
    w_wa_data = '0;
    w_wb_en   = 1'b0;
    w_wb_addr = load_index - IDX_W'(1);
    w_wb_data = -w_ld_ext;
    if (r_state == CLEAR) begin
      w_wa_en = 1'b1;
    end else if (w_load_acc) begin
      w_wa_en   = 1'b1;
      w_wa_addr = load_index;
      if (r_mode == MODE_MADD) begin
        w_wr_acc  = 1'b1;
        w_wa_data = w_ld_ext;
        w_wb_en   = (load_index != '0);
      end else begin
        w_wa_data = BIN_W'(1);
      end
    end
  end

  delta_bin_file #(
    .IDX_W (IDX_W),
    .BIN_W (BIN_W)
  ) u_bins (
    .clk     (clk),
    .wr_acc  (w_wr_acc),
    .wa_en   (w_wa_en),
    .wa_addr (w_wa_addr),
    .wa_data (w_wa_data),
    .wb_en   (w_wb_en),
    .wb_addr (w_wb_addr),
    .wb_data (w_wb_data),
    .rd_addr (r_idx),
    .rd_data (w_rd)
  );

  assign w_rd_nz = |w_rd;

  // Double integration: delta recovers per-index data, count is the running
  // sum of data at or above the index, total sums count once per index.
  assign w_delta_nx = r_delta + $signed(w_rd);
  assign w_count_nx = r_count + OUT_W'(w_delta_nx);

`ifdef DELTA_MADD_SAT_EN
  logic [OUT_W:0] w_sum;
  assign w_sum      = {1'b0, r_total} + {1'b0, w_count_nx};
  assign w_sat      = w_sum[OUT_W];
  assign w_total_nx = w_sat ? '1 : w_sum[OUT_W-1:0];
`else
  assign w_sat      = 1'b0;
  assign w_total_nx = r_total + w_count_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mode     <= MODE_MIN;
      r_idx      <= '0;
      r_delta    <= '0;
      r_count    <= '0;
      r_total    <= '0;
      result     <= '0;
      found      <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clear) begin
            r_state    <= CLEAR;
            r_mode     <= decode_mode(mode);
            r_idx      <= '0;
            ovf        <= 1'b0;
            busy       <= 1'b1;
            load_ready <= 1'b0;
          end else if (start) begin
            r_state    <= SCAN;
            r_idx      <= (r_mode == MODE_MIN) ? '0 : LAST_IDX;
            r_delta    <= '0;
            r_count    <= '0;
            r_total    <= '0;
            busy       <= 1'b1;
            load_ready <= 1'b0;
          end
        end

        CLEAR: begin
          if (r_idx == LAST_IDX) begin
            r_state <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end

        SCAN: begin
          case (r_mode)
            MODE_MIN: begin
              if (w_rd_nz || (r_idx == LAST_IDX)) begin
                result  <= w_rd_nz ? OUT_W'(r_idx) : '0;
                found   <= w_rd_nz;
                r_state <= DONE;
                done    <= 1'b1;
                busy    <= 1'b0;
              end else begin
                r_idx <= r_idx + IDX_W'(1);
              end
            end
            MODE_MAX: begin
              if (w_rd_nz || (r_idx == '0)) begin
                result  <= w_rd_nz ? OUT_W'(r_idx) : '0;
                found   <= w_rd_nz;
                r_state <= DONE;
                done    <= 1'b1;
                busy    <= 1'b0;
              end else begin
                r_idx <= r_idx - IDX_W'(1);
              end
            end
            default: begin
              r_delta <= w_delta_nx;
              r_count <= w_count_nx;
              r_total <= w_total_nx;
              ovf     <= ovf | w_sat;
              if (r_idx == '0) begin
                result  <= w_total_nx;
                found   <= 1'b1;
                r_state <= DONE;
                done    <= 1'b1;
                busy    <= 1'b0;
              end else begin
                r_idx <= r_idx - IDX_W'(1);
              end
            end
          endcase
        end

        DONE: begin
          r_state    <= IDLE;
          load_ready <= 1'b1;
        end

        default: begin
          r_state    <= IDLE;
          busy       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/delta_madd_engine.md
# delta_madd_engine

Parametrised successor to the 4-bit delta multiply-add unit. It keeps 2^IDX_W signed bins and accepts indexed data through a ready/valid load port. On start it runs one of three scans: MIN (lowest occupied index), MAX (highest occupied index) or MADD (Σ data×(index+1), computed by double-integrating delta-encoded bins). It sits between the operand loader and the result mux, and adds explicit clear, busy/done handshakes, early-terminating scans and optional saturation.

## Interface
- IDX_W, 4: index width; N = 2^IDX_W bins.
- DATA_W, 4: unsigned load data width.
- BIN_W, DATA_W+IDX_W+1: signed bin width.
- OUT_W, 16: unsigned result and accumulator width.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  2  00 MIN, 01 MAX, 10 MADD, 11 reserved (treated as MADD); captured on accepted clear.
- clear  in  1  zero all bins; accepted only when idle.
- start  in  1  begin scan in captured mode; accepted only when idle.
- load_valid  in  1  load request.
- load_ready  out  1  high exactly when idle.
- load_index  in  IDX_W  target bin.
- load_data  in  DATA_W  unsigned operand.
- busy  out  1  clear or scan in progress.
- done  out  1  one-cycle pulse at the end of a clear or scan.
- result  out  OUT_W  last scan result; held until the next scan's done.
- found  out  1  MIN/MAX hit flag; 1 after MADD.
- ovf  out  1  sticky saturation flag.

## Operation
- States: IDLE, CLEAR, SCAN, DONE. DONE lasts one cycle, then returns to IDLE.
- Priority in IDLE: clear > start. A load and a start can be accepted in the same cycle; the scan sees the load.
- Accepted load, MIN/MAX mode: bin[load_index] <= 1.
- Accepted load, MADD mode:
  - bin[load_index] += load_data.
  - bin[load_index-1] -= load_data; skipped when load_index = 0.
  - Both bins are written in the same cycle.
  - Bin arithmetic wraps modulo 2^BIN_W.
- CLEAR: zeroes one bin per cycle, index 0 to N-1.
- MIN scan: examines index 0 upward and stops at the first nonzero bin. result = index, found = 1.
- MAX scan: examines index N-1 downward and stops at the first nonzero bin. result = index, found = 1.
- MIN/MAX with no hit after N bins: result = 0, found = 0.
- MADD scan:
  - Examines index N-1 down to 0 in every case.
  - Each examined bin[i]: delta += bin[i]; count += delta; total += count.
  - result = total = Σ data×(index+1).
- Ignored while busy: load_valid (load_ready = 0), start and clear.
- Reset mid-operation: returns to IDLE immediately; no done pulse for the aborted operation.
- Reset values: busy 0, done 0, result 0, found 0, ovf 0, load_ready 1, captured mode MIN, accumulators 0.
- Bins are not reset; the first operation after reset must be a clear.
- ovf is cleared by an accepted clear or by reset.

## Timing
- Accept cycle = cycle 0. busy rises in cycle 1 and falls with done.
- CLEAR: bins written in cycles 1..N; done in cycle N+1.
- MIN hit at index k: examined in cycle k+1; done in cycle k+2.
- MAX hit at index k: examined in cycle N-k; done in cycle N-k+1.
- No hit, and MADD: done in cycle N+1.
- result and found update in the done cycle.
- load_ready returns high the cycle after done.

## Configuration
- DELTA_MADD_SAT_EN defined:
  - total saturates at 2^OUT_W-1.
  - ovf is set (sticky) when saturation occurs.
- DELTA_MADD_SAT_EN undefined:
  - total wraps modulo 2^OUT_W.
  - ovf is tied 0.

## Structure
- Package delta_madd_pkg holds:
  - mode enum (MODE_MIN, MODE_MAX, MODE_MADD);
  - state enum (IDLE, CLEAR, SCAN, DONE);
  - N derivation from IDX_W.
- Sub-module delta_bin_file: N×BIN_W register file with one combinational read port and two same-cycle write ports with distinct addresses.
- The FSM, scan counter and accumulators stay in the top module.

## Test plan
All scenarios use default parameters (N = 16).
- Reset, clear → done in cycle 17. Then MIN start with no loads → done in cycle 17, found 0, result 0.
- MIN: loads at indices 9, 5, 12, then start → done in cycle 7, result 5, found 1.
- MAX: same loads → done in cycle 5, result 12, found 1.
- MADD: loads (3,7), (0,2), (15,15) → done in cycle 17, result 270.
- load_valid and start asserted mid-scan → load_ready 0, bins unchanged, no second scan. Reset asserted mid-scan → busy 0 immediately, no done pulse.
- OUT_W=8, MADD load (15,15) twice → result 255 and ovf 1 with DELTA_MADD_SAT_EN; result 224 and ovf 0 without.
